// File: rtl/axi_common_pkg.sv
// ---------------------------------------------------------------------------
// axi_common
// Types shared by the AXI interconnect blocks.
//   axi_rr_arb_state_e : two-state round-robin address arbiter
//                        (IDLE = looking for a winner, BUSY = grant held
//                        until the downstream handshake).
// ---------------------------------------------------------------------------
package axi_common;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } axi_rr_arb_state_e;

endpackage : axi_common

// File: rtl/axi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rr_arbiter
// Round-robin arbiter for one AXI address channel (AW or AR). In IDLE it
// picks the first requester at or after the rotating pointer (only while
// 'allow' is high) and registers it into sel. In BUSY it presents s_valid
// and forwards s_ready to the selected master only. The grant is held until
// the downstream handshake, after which the pointer moves past the winner.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   allow       : gate on starting a new grant (e.g. downstream space free)
//   req[N]      : per-master xVALID
//   ready[N]    : per-master xREADY
//   s_valid     : downstream xVALID
//   s_ready     : downstream xREADY
//   sel         : registered index of the granted master
//   handshake   : s_valid & s_ready, for use by the parent
// ---------------------------------------------------------------------------
module axi_rr_arbiter
    import axi_common::*;
#(
    parameter int MASTER_NUM = 2,
    parameter int IDX_WIDTH  = $clog2(MASTER_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  allow,
    input  logic [MASTER_NUM-1:0] req,
    output logic [MASTER_NUM-1:0] ready,
    output logic                  s_valid,
    input  logic                  s_ready,
    output logic [IDX_WIDTH-1:0]  sel,
    output logic                  handshake
);

    axi_rr_arb_state_e      state_reg;
    logic [IDX_WIDTH-1:0]   ptr_reg;
    logic [IDX_WIDTH-1:0]   sel_reg;
    logic [IDX_WIDTH-1:0]   ptr_next;

    logic                   win_found;
    logic [IDX_WIDTH-1:0]   win_idx;
    logic [IDX_WIDTH:0]     cand;

    // Scan requesters starting at ptr_reg; one extra bit on cand keeps the
    // sum from overflowing before the modulo fold.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            cand = {1'b0, ptr_reg} + (IDX_WIDTH+1)'(i);
            if (cand >= (IDX_WIDTH+1)'(MASTER_NUM)) begin
                cand = cand - (IDX_WIDTH+1)'(MASTER_NUM);
            end
            if (!win_found && req[cand[IDX_WIDTH-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_WIDTH-1:0];
            end
        end
    end

    // Pointer after a handshake: one past the winner, wrapping.
    always_comb begin
        if (sel_reg == IDX_WIDTH'(MASTER_NUM - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = sel_reg + IDX_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            sel_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (allow && win_found) begin
                        sel_reg   <= win_idx;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_ready) begin
                        ptr_reg   <= ptr_next;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // s_valid depends on registered state only; s_ready never feeds back.
    assign s_valid   = (state_reg == BUSY);
    assign sel       = sel_reg;
    assign handshake = s_valid & s_ready;

    for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_ready
        assign ready[gi] = s_valid && s_ready && (sel_reg == IDX_WIDTH'(gi));
    end

endmodule : axi_rr_arbiter

// File: rtl/axi_mux_arbiter.sv
// ---------------------------------------------------------------------------
// axi_mux_arbiter
// Control side of an N-to-1 AXI multiplexer. AW and AR are arbitrated
// independently (round robin, grant held to handshake). Every AW handshake
// pushes the granted index into a small FIFO; the W channel is routed from
// the FIFO head and the entry is popped on the WLAST handshake, so write
// bursts leave in AW order and never interleave. Payload muxing is external.
//
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   aw_valid/aw_ready[N]             : upstream AW handshake
//   s_aw_valid/s_aw_ready, aw_sel    : downstream AW handshake + select
//   ar_valid/ar_ready[N]             : upstream AR handshake
//   s_ar_valid/s_ar_ready, ar_sel    : downstream AR handshake + select
//   w_valid/w_last/w_ready[N]        : upstream W handshake
//   s_w_valid/s_w_ready, w_sel       : downstream W handshake + select
// ---------------------------------------------------------------------------
module axi_mux_arbiter
    import axi_common::*;
#(
    parameter int MASTER_NUM   = 2,
    parameter int W_FIFO_DEPTH = 4,
    parameter int IDX_WIDTH    = $clog2(MASTER_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MASTER_NUM-1:0] aw_valid,
    output logic [MASTER_NUM-1:0] aw_ready,
    output logic                  s_aw_valid,
    input  logic                  s_aw_ready,
    output logic [IDX_WIDTH-1:0]  aw_sel,
    input  logic [MASTER_NUM-1:0] ar_valid,
    output logic [MASTER_NUM-1:0] ar_ready,
    output logic                  s_ar_valid,
    input  logic                  s_ar_ready,
    output logic [IDX_WIDTH-1:0]  ar_sel,
    input  logic [MASTER_NUM-1:0] w_valid,
    input  logic [MASTER_NUM-1:0] w_last,
    output logic [MASTER_NUM-1:0] w_ready,
    output logic                  s_w_valid,
    input  logic                  s_w_ready,
    output logic [IDX_WIDTH-1:0]  w_sel
);

    localparam int CNT_W = $clog2(W_FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(W_FIFO_DEPTH);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 aw_push;
    logic                 w_pop;
    logic                 ar_handshake;

    logic [IDX_WIDTH-1:0] fifo_mem_reg [W_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [CNT_W-1:0]     count_next;

    // AW may only start a grant when its eventual push is guaranteed room.
    axi_rr_arbiter #(
        .MASTER_NUM (MASTER_NUM),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_aw_arb (
        .clk       (clk),
        .rst       (rst),
        .allow     (!fifo_full),
        .req       (aw_valid),
        .ready     (aw_ready),
        .s_valid   (s_aw_valid),
        .s_ready   (s_aw_ready),
        .sel       (aw_sel),
        .handshake (aw_push)
    );

    axi_rr_arbiter #(
        .MASTER_NUM (MASTER_NUM),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_ar_arb (
        .clk       (clk),
        .rst       (rst),
        .allow     (1'b1),
        .req       (ar_valid),
        .ready     (ar_ready),
        .s_valid   (s_ar_valid),
        .s_ready   (s_ar_ready),
        .sel       (ar_sel),
        .handshake (ar_handshake)
    );

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(W_FIFO_DEPTH));

    // Head is read straight from the tiny index store so a pushed entry is
    // routable the very next cycle; no bypass from the push side.
    assign w_sel     = fifo_empty ? '0 : fifo_mem_reg[rd_ptr_reg];
    assign s_w_valid = !fifo_empty && w_valid[w_sel];
    assign w_pop     = s_w_valid && s_w_ready && w_last[w_sel];

    for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_w_ready
        assign w_ready[gi] = !fifo_empty && s_w_ready && (w_sel == IDX_WIDTH'(gi));
    end

    always_comb begin
        count_next = count_reg;
        case ({aw_push, w_pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (aw_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Storage needs no reset: entries are only observed while count > 0.
    always_ff @(posedge clk) begin
        if (aw_push) begin
            fifo_mem_reg[wr_ptr_reg] <= aw_sel;
        end
    end

    logic unused_ok;
    assign unused_ok = ar_handshake;

endmodule : axi_mux_arbiter
